// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two FIFO; 8N1-style framing with
// configurable data bits, optional even/odd parity and 1 or 2 stop bits.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / UART_BPS;
  localparam int unsigned STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int unsigned CW       = $clog2(STOP_LEN + 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_V   = (AW + 1)'(FIFO_DEPTH);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_nxt;
  logic [CW-1:0]        baud_cnt, baud_nxt;
  logic [2:0]           bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_bit, par_nxt;
  logic                 txd, txd_nxt;

  assign tx_ready   = (count < DEPTH_V);
  assign push       = tx_valid & tx_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count;
  assign uart_txd   = txd;
  assign tx_busy    = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      txd      <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      par_bit  <= par_nxt;
      txd      <= txd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    par_nxt   = par_bit;
    txd_nxt   = txd;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        txd_nxt  = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          shift_nxt = head;
          par_nxt   = (^head) ^ ODD_PAR;
          bit_nxt   = '0;
          txd_nxt   = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          txd_nxt   = shift[0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = (PARITY != 0) ? PAR : STOP;
            txd_nxt   = (PARITY != 0) ? par_bit : 1'b1;
          end else begin
            txd_nxt = shift[1];
          end
        end
      end
      PAR: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          txd_nxt   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        // Stop time spans all stop bits in one count so the next frame
        // can start on the very edge the last stop bit ends.
        if (baud_cnt == STOP_LAST) begin
          baud_nxt = '0;
          if (count != '0) begin
            pop       = 1'b1;
            shift_nxt = head;
            par_nxt   = (^head) ^ ODD_PAR;
            bit_nxt   = '0;
            txd_nxt   = 1'b0;
            state_nxt = START;
          end else begin
            txd_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        txd_nxt   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a cycle-level frame-timeline model checks the main
// instance every cycle; two extra instances pin parity and frame length.
module tb_uart_tx_fifo;

  localparam int BD    = 16;
  localparam int FRAME = 10 * BD;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance: 8 data, no parity, 1 stop, depth 4
  logic       valid_a;
  logic [7:0] data_a;
  logic       ready_a, txd_a, busy_a;
  logic [2:0] count_a;
  // 7 data, even parity, 2 stop
  logic       valid_b;
  logic [6:0] data_b;
  logic       ready_b, txd_b, busy_b;
  logic [2:0] count_b;
  // 8 data, odd parity, 1 stop
  logic       valid_c;
  logic [7:0] data_c;
  logic       ready_c, txd_c, busy_c;
  logic [2:0] count_c;

  uart_tx_fifo #(.CLK_FREQ(16), .UART_BPS(1), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid_a), .tx_data(data_a),
    .tx_ready(ready_a), .uart_txd(txd_a), .tx_busy(busy_a), .fifo_count(count_a));

  uart_tx_fifo #(.CLK_FREQ(16), .UART_BPS(1), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid_b), .tx_data(data_b),
    .tx_ready(ready_b), .uart_txd(txd_b), .tx_busy(busy_b), .fifo_count(count_b));

  uart_tx_fifo #(.CLK_FREQ(16), .UART_BPS(1), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid_c), .tx_data(data_c),
    .tx_ready(ready_c), .uart_txd(txd_c), .tx_busy(busy_c), .fifo_count(count_c));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: byte queue plus the position of the current frame on its timeline.
  logic [7:0] mq[$];
  bit         m_fl;
  int         m_k;
  logic [7:0] m_byte;
  bit         m_acc, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_fl = 1'b0;
      m_k  = 0;
    end else begin
      m_acc = valid_a && (mq.size() < 4);
      m_pop = (mq.size() != 0) && (!m_fl || m_k == FRAME - 1);
      if (m_fl && m_k == FRAME - 1 && !m_pop) m_fl = 1'b0;
      else if (m_fl) m_k++;
      if (m_pop) begin
        m_byte = mq.pop_front();
        m_fl   = 1'b1;
        m_k    = 0;
      end
      if (m_acc) mq.push_back(data_a);
    end
  end

  function automatic logic model_txd();
    int i;
    if (!m_fl) return 1'b1;
    i = m_k / BD;
    if (i == 0) return 1'b0;
    if (i <= 8) return m_byte[i-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("txd",   {31'd0, txd_a},   {31'd0, model_txd()});
      check("ready", {31'd0, ready_a}, {31'd0, mq.size() < 4});
      check("busy",  {31'd0, busy_a},  {31'd0, m_fl || mq.size() != 0});
      check("count", {29'd0, count_a}, mq.size());
    end
  end

  // Independent line decoder for the main instance.
  logic [7:0] rx_q[$];
  int         rx_k = -1;
  logic [7:0] rx_sh;
  always @(negedge clk) begin
    if (!rst_n) rx_k = -1;
    else if (rx_k < 0) begin
      if (txd_a == 1'b0) rx_k = 0;
    end else begin
      rx_k++;
      if (rx_k % BD == BD / 2 && rx_k / BD >= 1 && rx_k / BD <= 8)
        rx_sh[rx_k / BD - 1] = txd_a;
      if (rx_k == 9 * BD + BD / 2) rx_q.push_back(rx_sh);
      if (rx_k == FRAME - 1) rx_k = -1;
    end
  end

  function automatic logic line(input int s);
    return (s == 0) ? txd_a : (s == 1) ? txd_b : txd_c;
  endfunction
  function automatic logic busy(input int s);
    return (s == 0) ? busy_a : (s == 1) ? busy_b : busy_c;
  endfunction

  // Called on a negedge: holds valid_a until the byte is accepted.
  task automatic send_a(input logic [7:0] d);
    bit acc;
    int t;
    valid_a = 1'b1;
    data_a  = d;
    t = 0;
    do begin
      acc = ready_a;
      @(negedge clk);
      t++;
    end while (!acc && t < 2000);
    if (!acc) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_frame(input int s, input int nbits, input logic [15:0] expb,
                             input int exp_len, input string nm);
    int t;
    int k;
    t = 0;
    while (line(s) !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_start"}, {31'd0, line(s)}, 32'd0);
    if (t < 200) begin
      k = 0;
      while (busy(s) && k < 600) begin
        if (k % BD == BD / 2 && k / BD < nbits)
          check($sformatf("%s_bit%0d", nm, k / BD), {31'd0, line(s)}, {31'd0, expb[k / BD]});
        k++;
        @(negedge clk);
      end
      check({nm, "_len"}, k, exp_len);
    end
  endtask

  string hello = "Hello World!\n";

  initial begin
    int t;
    int lows;
    valid_a = 1'b0; data_a = '0;
    valid_b = 1'b0; data_b = '0;
    valid_c = 1'b0; data_c = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_txd",   {31'd0, txd_a},   32'd1);
    check("rst_ready", {31'd0, ready_a}, 32'd1);
    check("rst_busy",  {31'd0, busy_a},  32'd0);
    check("rst_count", {29'd0, count_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // single 0x48 frame
    send_a(8'h48);
    valid_a = 1'b0;
    check_frame(0, 10, 16'b1010010000, 160, "f48");

    // 0x6C with 7 data bits, even parity, 2 stops
    valid_b = 1'b1; data_b = 7'h6C;
    @(negedge clk);
    valid_b = 1'b0;
    check_frame(1, 11, 16'b11011011000, 176, "even");

    // 0x6C with 8 data bits, odd parity
    valid_c = 1'b1; data_c = 8'h6C;
    @(negedge clk);
    valid_c = 1'b0;
    check_frame(2, 11, 16'b11011011000, 176, "odd");

    // burst into a depth-4 FIFO with valid held throughout
    rx_q.delete();
    for (int i = 0; i < hello.len(); i++) send_a(hello[i]);
    valid_a = 1'b0;
    t = 0;
    while (busy_a && t < 3000) begin @(negedge clk); t++; end
    check("burst_drain", {31'd0, busy_a}, 32'd0);
    check("burst_len", rx_q.size(), hello.len());
    for (int i = 0; i < hello.len() && i < rx_q.size(); i++)
      check($sformatf("burst_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, hello[i]});

    // reset in the third data bit with two bytes still queued
    send_a(8'hA5);
    send_a(8'h3C);
    send_a(8'h0F);
    valid_a = 1'b0;
    t = 0;
    while (txd_a !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    repeat (BD + 2 * BD + BD / 2 - 1) @(negedge clk);
    check("pre_rst_count", {29'd0, count_a}, 32'd2);
    check("pre_rst_bit2", {31'd0, txd_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_txd",   {31'd0, txd_a},   32'd1);
    check("arst_count", {29'd0, count_a}, 32'd0);
    check("arst_busy",  {31'd0, busy_a},  32'd0);
    check("arst_ready", {31'd0, ready_a}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0) lows++;
    end
    check("post_rst_idle", lows, 32'd0);

    // randomized traffic with varying write density
    repeat (6) begin
      int dens;
      dens = $urandom_range(0, 8);
      repeat (500) begin
        valid_a = ($urandom_range(0, 7) < dens);
        data_a  = 8'($urandom);
        @(negedge clk);
      end
    end
    valid_a = 1'b0;
    t = 0;
    while (busy_a && t < 2000) begin @(negedge clk); t++; end
    check("rand_drain", {31'd0, busy_a}, 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
